pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding, counter
// widths and the state-to-control decode.
package pipe_ctrl_pkg;

    localparam int STALL_CNT_W = 16;
    localparam int WAIT_CNT_W  = 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_BUBBLE  = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    // Pipeline-register controls produced by the controller, one set per state.
    typedef struct packed {
        logic fd_en;
        logic dx_en;
        logic xm_en;
        logic mw_en;
        logic fd_flush;
        logic dx_flush;
        logic xm_nop;
    } ctrl_t;

    // Moore decode: every control except the counters depends on state alone.
    function automatic ctrl_t decode_ctrl(state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_RUN: begin
                c.fd_en = 1'b1; c.dx_en = 1'b1; c.xm_en = 1'b1; c.mw_en = 1'b1;
            end
            ST_BUBBLE: begin
                // Hold fetch/decode, push a NOP into execute->memory.
                c.xm_en = 1'b1; c.mw_en = 1'b1; c.xm_nop = 1'b1;
            end
            ST_FLUSH: begin
                c.fd_en = 1'b1; c.dx_en = 1'b1; c.xm_en = 1'b1; c.mw_en = 1'b1;
                c.fd_flush = 1'b1; c.dx_flush = 1'b1;
            end
            default: c = '0;  // MEMWAIT and HALT freeze the whole pipe
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath/hazard logic and pipe_ctrl.
//
// Handshake: dmem_req_i marks a memory-stage data access issued this cycle;
// dmem_ack_i completes the outstanding access. An access acked in the same
// cycle it is requested costs nothing; otherwise the pipe freezes until the
// cycle after the ack is seen. All other inputs are single-cycle level
// requests sampled on the rising clock edge.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic bubble_i;
    logic branch_taken_i;
    logic dmem_req_i;
    logic dmem_ack_i;
    logic halt_i;

    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_flush;
    logic dx_flush;
    logic xm_nop;
    logic [2:0]             state_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    logic [WAIT_CNT_W-1:0]  wait_cnt_o;

    modport master (
        output bubble_i, branch_taken_i, dmem_req_i, dmem_ack_i, halt_i,
        input  fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_nop,
        input  state_o, stall_cnt_o, wait_cnt_o
    );

    modport slave (
        input  bubble_i, branch_taken_i, dmem_req_i, dmem_ack_i, halt_i,
        output fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_nop,
        output state_o, stall_cnt_o, wait_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stalls, bubbles, flushes and memory waits,
// plus stall/wait statistics counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    pipe_ctrl_if.slave ctl
);

    state_e                 state_q, state_d, state_vis;
    logic                   halt_pend_q, halt_pend_d;
    logic                   enter_memwait;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q;
    ctrl_t                  ctrl;

    // State register and pending-halt flag (halt seen mid-MEMWAIT, acted on at ack).
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= ST_RUN;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Next-state logic; only halt_i and dmem_ack_i matter outside RUN.
    always_comb begin
        state_d       = state_q;
        halt_pend_d   = halt_pend_q;
        enter_memwait = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ctl.halt_i) begin
                    state_d = ST_HALT;
                end else if (ctl.dmem_req_i && !ctl.dmem_ack_i) begin
                    state_d       = ST_MEMWAIT;
                    halt_pend_d   = 1'b0;
                    enter_memwait = 1'b1;
                end else if (ctl.branch_taken_i) begin
                    state_d = ST_FLUSH;
                end else if (ctl.bubble_i) begin
                    state_d = ST_BUBBLE;
                end
            end
            ST_BUBBLE, ST_FLUSH: begin
                state_d = ctl.halt_i ? ST_HALT : ST_RUN;
            end
            ST_MEMWAIT: begin
                if (ctl.halt_i) halt_pend_d = 1'b1;
                if (ctl.dmem_ack_i) begin
                    state_d = (ctl.halt_i || halt_pend_q) ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // While reset is asserted the outputs already present RUN values.
    always_comb begin
        state_vis = n_reset ? state_q : ST_RUN;
        ctrl      = decode_ctrl(state_vis);
    end

    // Stall counter: cycles with fetch held, not counting the halted state.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            stall_cnt_q <= '0;
        end else if (!ctrl.fd_en && (state_q != ST_HALT)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Wait counter: cleared on MEMWAIT entry, saturating count of MEMWAIT cycles.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wait_cnt_q <= '0;
        end else if (enter_memwait) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ST_MEMWAIT) && (wait_cnt_q != WAIT_CNT_MAX)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign ctl.fd_en       = ctrl.fd_en;
    assign ctl.dx_en       = ctrl.dx_en;
    assign ctl.xm_en       = ctrl.xm_en;
    assign ctl.mw_en       = ctrl.mw_en;
    assign ctl.fd_flush    = ctrl.fd_flush;
    assign ctl.dx_flush    = ctrl.dx_flush;
    assign ctl.xm_nop      = ctrl.xm_nop;
    assign ctl.state_o     = state_vis;
    assign ctl.stall_cnt_o = stall_cnt_q;
    assign ctl.wait_cnt_o  = wait_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    pipe_ctrl_if u_if ();

    pipe_ctrl dut (
        .clk     (clk),
        .n_reset (n_reset),
        .ctl     (u_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Mode numbers follow the published encoding: 0 run, 1 bubble, 2 flush,
    // 3 memory wait, 4 halt.
    int m_st    = 0;
    bit m_hp    = 0;
    int m_stall = 0;
    int m_wait  = 0;

    function automatic void model_clock(bit rst_n, bit bub, bit br, bit req, bit ack, bit halt);
        if (!rst_n) begin
            m_st = 0; m_hp = 0; m_stall = 0; m_wait = 0;
            return;
        end
        if (m_st == 1 || m_st == 3) m_stall = (m_stall + 1) % 65536;
        if (m_st == 3 && m_wait < 255) m_wait = m_wait + 1;
        case (m_st)
            0: begin
                if (halt)              m_st = 4;
                else if (req && !ack) begin m_st = 3; m_wait = 0; m_hp = 0; end
                else if (br)           m_st = 2;
                else if (bub)          m_st = 1;
            end
            1, 2: m_st = halt ? 4 : 0;
            3: begin
                if (halt) m_hp = 1;
                if (ack)  m_st = m_hp ? 4 : 0;
            end
            default: m_st = 4;
        endcase
    endfunction

    // Expected {fd_en,dx_en,xm_en,mw_en,fd_flush,dx_flush,xm_nop} per mode.
    function automatic logic [6:0] exp_ctrl(int st);
        case (st)
            0:       return 7'b1111_000;
            1:       return 7'b0011_001;
            2:       return 7'b1111_110;
            default: return 7'b0000_000;
        endcase
    endfunction

    function automatic logic [6:0] act_ctrl();
        return {u_if.fd_en, u_if.dx_en, u_if.xm_en, u_if.mw_en,
                u_if.fd_flush, u_if.dx_flush, u_if.xm_nop};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_st(string name, int st);
        check({name, " state"}, 32'(u_if.state_o), st);
        check({name, " ctrl"},  32'(act_ctrl()),   32'(exp_ctrl(st)));
    endtask

    task automatic check_all(string name, int st, int stall, int wt);
        check_st(name, st);
        check({name, " stall"}, 32'(u_if.stall_cnt_o), stall);
        check({name, " wait"},  32'(u_if.wait_cnt_o),  wt);
    endtask

    // ---------------- driver ----------------
    task automatic drive(bit bub, bit br, bit req, bit ack, bit halt);
        u_if.bubble_i       = bub;
        u_if.branch_taken_i = br;
        u_if.dmem_req_i     = req;
        u_if.dmem_ack_i     = ack;
        u_if.halt_i         = halt;
    endtask

    // One clock: apply inputs, advance model, sample 1ns after the edge.
    task automatic cyc(bit rst_n, bit bub, bit br, bit req, bit ack, bit halt);
        n_reset = rst_n;
        drive(bub, br, req, ack, halt);
        model_clock(rst_n, bub, br, req, ack, halt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        bit    bub, br, req, ack, halt;
        int    exp_st;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        // Outputs show RUN values while reset is held, before any edge.
        check_st("reset_hold", 0);
        do_reset();
        check_all("reset_edge", 0, 0, 0);

        vecs.push_back('{"idle",          0, 0, 0, 0, 0, 0});
        vecs.push_back('{"bubble",        1, 0, 0, 0, 0, 1});
        vecs.push_back('{"branch",        0, 1, 0, 0, 0, 2});
        vecs.push_back('{"branch_bubble", 1, 1, 0, 0, 0, 2});
        vecs.push_back('{"mem_miss",      0, 0, 1, 0, 0, 3});
        vecs.push_back('{"mem_hit",       0, 0, 1, 1, 0, 0});
        vecs.push_back('{"miss_over_br",  1, 1, 1, 0, 0, 3});
        vecs.push_back('{"hit_branch",    0, 1, 1, 1, 0, 2});
        vecs.push_back('{"halt_over_all", 1, 1, 1, 0, 1, 4});
        vecs.push_back('{"hit_bubble",    1, 0, 1, 1, 0, 1});
        vecs.push_back('{"ack_alone",     0, 0, 0, 1, 0, 0});
        vecs.push_back('{"halt",          0, 0, 0, 0, 1, 4});

        foreach (vecs[i]) begin
            int st2;
            do_reset();
            cyc(1, vecs[i].bub, vecs[i].br, vecs[i].req, vecs[i].ack, vecs[i].halt);
            check_all({vecs[i].name, " c1"}, vecs[i].exp_st, 0, 0);
            idle();
            st2 = (vecs[i].exp_st == 1 || vecs[i].exp_st == 2) ? 0 : vecs[i].exp_st;
            check_all({vecs[i].name, " c2"}, st2,
                      (vecs[i].exp_st == 1 || vecs[i].exp_st == 3) ? 1 : 0,
                      (vecs[i].exp_st == 3) ? 1 : 0);
        end

        // ---- bubble: one cycle then back to RUN ----
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        check_all("bub_in", 1, 0, 0);
        idle();
        check_all("bub_out", 0, 1, 0);

        // ---- inputs other than halt/ack ignored outside RUN ----
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        check_all("bub_ignore", 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0);
        check_st("flush_in", 2);
        cyc(1, 1, 1, 1, 0, 0);
        check_st("flush_ignore", 0);

        // ---- memory wait: 6 MEMWAIT cycles, ack in the 6th ----
        do_reset();
        cyc(1, 0, 0, 1, 0, 0);
        check_all("mw_entry", 3, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(1, 1, 1, 1, 0, 0);
        check_all("mw_mid", 3, 5, 5);
        cyc(1, 0, 0, 0, 1, 0);
        check_all("mw_exit", 0, 6, 6);
        idle();
        check_all("mw_hold", 0, 6, 6);

        // ---- halt at normal exit of BUBBLE and FLUSH ----
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check_all("bub_halt", 4, 1, 0);
        do_reset();
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check_all("flush_halt", 4, 0, 0);

        // ---- halt inside MEMWAIT waits for ack, then reset recovers ----
        do_reset();
        cyc(1, 0, 0, 1, 0, 0);
        idle();
        idle();
        cyc(1, 0, 0, 0, 0, 1);
        check_st("mw_halt_pend", 3);
        idle();
        cyc(1, 0, 0, 0, 1, 0);
        check_all("mw_halt", 4, 5, 5);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, $urandom_range(0, 1), 0);
        check_all("halt_frozen", 4, 5, 5);
        do_reset();
        check_all("halt_reset", 0, 0, 0);
        idle();
        check_all("halt_reset_run", 0, 0, 0);

        // ---- reset mid-MEMWAIT ----
        cyc(1, 0, 0, 1, 0, 0);
        idle();
        idle();
        do_reset();
        check_all("mw_reset", 0, 0, 0);

        // ---- long wait: saturation, then stall counter wrap ----
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 65532; i++) begin
            idle();
            if (i == 254) check_all("sat_254", 3, 254, 254);
            if (i == 300) check_all("sat_300", 3, 300, 255);
        end
        cyc(1, 0, 0, 0, 1, 0);
        check_all("long_exit", 0, 16'hFFFD, 255);
        cyc(1, 1, 0, 0, 0, 0);
        idle();
        check_all("wrap_fffe", 0, 16'hFFFE, 255);
        cyc(1, 1, 0, 0, 0, 0);
        idle();
        check_all("wrap_ffff", 0, 16'hFFFF, 255);
        cyc(1, 1, 0, 0, 0, 0);
        check_all("wrap_last", 1, 16'hFFFF, 255);
        idle();
        check_all("wrap_zero", 0, 0, 255);

        // ---- randomized run against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rst_n, bub, br, req, ack, halt;
            rst_n = (m_st == 4) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 499) != 0);
            bub   = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 5) == 0);
            req   = ($urandom_range(0, 3) == 0);
            ack   = (m_st == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            halt  = ($urandom_range(0, 149) == 0);
            cyc(rst_n, bub, br, req, ack, halt);
            check_all("rand", m_st, m_stall, m_wait);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
